// File: rtl/pipe_hazard_unit_pkg.sv
// ---------------------------------------------------------------------------
// pipe_hazard_unit_pkg
// Shared constants for the pipeline hazard unit: register-number width,
// forward-select width and encodings, and the tracking-entry record kept for
// every stage after ID.
//
// Forward-select encoding (3 bits):
//   FWD_REGFILE  = 0        operand comes from the register file
//   fwd_alu(k)   = 2k+1     ALU result held in stage k
//   fwd_load(k)  = 2k+2     load data held in stage k (k >= 1 only)
// ---------------------------------------------------------------------------
package pipe_hazard_unit_pkg;

    localparam int REG_W = 5;
    localparam int FWD_W = 3;
    localparam int CNT_W = 16;

    // Only EXE, MEM and WB can be forwarded from. Anything deeper has
    // already been written back, and its select code would not fit in
    // FWD_W bits anyway.
    localparam int FWD_STAGES_MAX = 3;

    localparam logic [FWD_W-1:0] FWD_REGFILE = 3'd0;

    typedef struct packed {
        logic             valid;
        logic             wen;
        logic [REG_W-1:0] dst;
        logic             is_load;
        logic             is_mem;
    } entry_t;

    function automatic logic [FWD_W-1:0] fwd_alu(input int k);
        return FWD_W'(2 * k + 1);
    endfunction

    function automatic logic [FWD_W-1:0] fwd_load(input int k);
        return FWD_W'(2 * k + 2);
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// ---------------------------------------------------------------------------
// hazard_fwd_sel
// Priority search for one source operand: picks the youngest tracked stage
// that will write the register this operand reads, and encodes where the
// value should be taken from.
//
// Ports:
//   id_valid   in   ID holds a real instruction
//   src        in   source register number
//   use_src    in   the source is actually read
//   ent_valid  in   per-stage entry valid
//   ent_wen    in   per-stage register write enable
//   ent_load   in   per-stage "is a load"
//   ent_dst    in   per-stage destination register
//   sel        out  forward select (FWD_REGFILE / fwd_alu / fwd_load)
// ---------------------------------------------------------------------------
module hazard_fwd_sel
    import pipe_hazard_unit_pkg::*;
#(
    parameter int N = 3
) (
    input  logic                      id_valid,
    input  logic [REG_W-1:0]          src,
    input  logic                      use_src,
    input  logic [N-1:0]              ent_valid,
    input  logic [N-1:0]              ent_wen,
    input  logic [N-1:0]              ent_load,
    input  logic [N-1:0][REG_W-1:0]   ent_dst,
    output logic [FWD_W-1:0]          sel
);

    // Walk from the oldest stage to the youngest so that the youngest match
    // overwrites older ones. Register 0 is hard-wired zero, so it never
    // forwards. A load in stage 0 has no data yet; that case is a load-use
    // stall handled in the top, and the select shown meanwhile is unused.
    always_comb begin
        sel = FWD_REGFILE;
        if (id_valid && use_src && (src != '0)) begin
            for (int k = N - 1; k >= 0; k--) begin
                if (ent_valid[k] && ent_wen[k] && (ent_dst[k] == src)) begin
                    sel = (ent_load[k] && (k >= 1)) ? fwd_load(k) : fwd_alu(k);
                end
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// ---------------------------------------------------------------------------
// pipe_hazard_unit
// Hazard detection and forwarding control for an in-order pipeline.
// Tracks every instruction that has left ID (stage 0 = EXE, 1 = MEM,
// 2 = WB, ...) and produces forwarding selects, load-use stalls, memory-wait
// freezes and redirect flushes.
//
// Parameters:
//   STAGES    tracked stages after ID (2..6)
//   WAIT_MAX  freeze cycles before mem_timeout is raised (1..65535)
//
// Build option:
//   HAZARD_TIMEOUT_EN  when defined, a 16-bit saturating counter measures
//                      consecutive freeze cycles and raises the sticky
//                      mem_timeout; when undefined, mem_timeout is 0 and the
//                      unit waits on memory indefinitely.
//
// Ports:
//   clk, rst_n                rising-edge clock, async active-low reset
//   id_valid                  ID holds a real instruction
//   id_rs, id_rt              ID source registers
//   id_use_rs, id_use_rt      matching source is read
//   id_wen, id_wdst           ID instruction writes id_wdst
//   id_is_load, id_is_mem     ID is lw; ID is lw or sw
//   redirect                  ID-resolved jump/branch taken
//   mio_ready                 data memory ready
//   fwd_sel_rs, fwd_sel_rt    forward selects
//   stall_if_id               hold PC and IF/ID
//   bubble_ex                 inject NOP into EXE
//   flush_if_id               squash IF/ID
//   freeze                    hold every pipeline register
//   mem_timeout               sticky memory-wait timeout
// ---------------------------------------------------------------------------
module pipe_hazard_unit
    import pipe_hazard_unit_pkg::*;
#(
    parameter int STAGES   = 3,
    parameter int WAIT_MAX = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_wen,
    input  logic [REG_W-1:0] id_wdst,
    input  logic             id_is_load,
    input  logic             id_is_mem,
    input  logic             redirect,
    input  logic             mio_ready,
    output logic [FWD_W-1:0] fwd_sel_rs,
    output logic [FWD_W-1:0] fwd_sel_rt,
    output logic             stall_if_id,
    output logic             bubble_ex,
    output logic             flush_if_id,
    output logic             freeze,
    output logic             mem_timeout
);

    localparam int NFWD = (STAGES < FWD_STAGES_MAX) ? STAGES : FWD_STAGES_MAX;

    entry_t [STAGES-1:0] ent_q;
    entry_t              id_entry;

    logic mem_wait;
    logic load_use;
    logic rs_hit0;
    logic rt_hit0;

    logic [NFWD-1:0]            fv_valid;
    logic [NFWD-1:0]            fv_wen;
    logic [NFWD-1:0]            fv_load;
    logic [NFWD-1:0][REG_W-1:0] fv_dst;

    // Stages past the forwarding window only shift; the last one is dropped.
    logic unused_entry_bits;
    assign unused_entry_bits = ^ent_q;

    // Hazard decisions. Memory wait outranks the load-use stall, which
    // outranks a redirect: a redirect seen while ID is held is simply
    // ignored because ID presents the same branch again next cycle.
    always_comb begin
        id_entry         = '0;
        id_entry.valid   = 1'b1;
        id_entry.wen     = id_wen;
        id_entry.dst     = id_wdst;
        id_entry.is_load = id_is_load;
        id_entry.is_mem  = id_is_mem;

        mem_wait = ent_q[1].valid && ent_q[1].is_mem && !mio_ready;

        rs_hit0  = id_use_rs && (id_rs != '0) && (ent_q[0].dst == id_rs);
        rt_hit0  = id_use_rt && (id_rt != '0) && (ent_q[0].dst == id_rt);
        load_use = id_valid && ent_q[0].valid && ent_q[0].wen &&
                   ent_q[0].is_load && (rs_hit0 || rt_hit0);

        freeze      = mem_wait;
        stall_if_id = mem_wait || load_use;
        bubble_ex   = load_use && !mem_wait;
        flush_if_id = redirect && !mem_wait && !load_use;
    end

    // Tracking pipeline: advances in lock-step with the datapath and holds
    // while frozen. A bubble or an empty ID slot enters as an invalid entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_q <= '0;
        end else if (!freeze) begin
            ent_q[0] <= (id_valid && !bubble_ex) ? id_entry : '0;
            for (int k = 1; k < STAGES; k++) begin
                ent_q[k] <= ent_q[k-1];
            end
        end
    end

    // Split the forwardable stages into plain vectors for the search blocks.
    always_comb begin
        fv_valid = '0;
        fv_wen   = '0;
        fv_load  = '0;
        fv_dst   = '0;
        for (int k = 0; k < NFWD; k++) begin
            fv_valid[k] = ent_q[k].valid;
            fv_wen[k]   = ent_q[k].wen;
            fv_load[k]  = ent_q[k].is_load;
            fv_dst[k]   = ent_q[k].dst;
        end
    end

    hazard_fwd_sel #(.N(NFWD)) u_fwd_rs (
        .id_valid  (id_valid),
        .src       (id_rs),
        .use_src   (id_use_rs),
        .ent_valid (fv_valid),
        .ent_wen   (fv_wen),
        .ent_load  (fv_load),
        .ent_dst   (fv_dst),
        .sel       (fwd_sel_rs)
    );

    hazard_fwd_sel #(.N(NFWD)) u_fwd_rt (
        .id_valid  (id_valid),
        .src       (id_rt),
        .use_src   (id_use_rt),
        .ent_valid (fv_valid),
        .ent_wen   (fv_wen),
        .ent_load  (fv_load),
        .ent_dst   (fv_dst),
        .sel       (fwd_sel_rt)
    );

`ifdef HAZARD_TIMEOUT_EN
    localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(WAIT_MAX);

    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_q;
    logic [CNT_W:0]   cnt_inc;

    // One bit wider so the compare still works once the counter saturates.
    assign cnt_inc = {1'b0, wait_cnt} + {{CNT_W{1'b0}}, 1'b1};

    // Counts consecutive freeze cycles; the flag is sticky until reset and
    // does not change how the freeze itself behaves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else if (freeze) begin
            if (wait_cnt != {CNT_W{1'b1}}) begin
                wait_cnt <= cnt_inc[CNT_W-1:0];
            end
            if (cnt_inc >= {1'b0, WAIT_LIM}) begin
                timeout_q <= 1'b1;
            end
        end else begin
            wait_cnt <= '0;
        end
    end

    assign mem_timeout = timeout_q;
`else
    localparam int unused_wait_max = WAIT_MAX;
    assign mem_timeout = 1'b0;
`endif

endmodule
